// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the EX-stage ALU.
// Opcodes 0-7 keep the encodings of the earlier combinational ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_NOR  = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier: one partial product per step, WIDTH steps.
// done and result are combinational on the final step so the owner can register them.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_sum;

    always_comb begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    assign done   = step && (cnt_q == CNT_W'(WIDTH - 1));
    assign result = acc_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU: single-cycle ops with latency 1, iterative MUL,
// valid/ready on both sides, zero/overflow flags and a passthrough destination tag.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_aluc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_ovf
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_r_q, out_r_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_zero_q, out_zero_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_known;
    logic             sa, sb, sr;

    assign in_ready  = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (in_aluc == ALU_MUL);
    assign shamt     = in_a[SHAMT_W-1:0];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .step   (state_q == ST_MUL),
        .a      (in_a),
        .b      (in_b),
        .done   (mul_done),
        .result (mul_result)
    );

    // Single-cycle datapath; opcodes 12-15 (and MUL here) produce 0 with flags forced low.
    always_comb begin
        alu_res   = '0;
        alu_known = 1'b1;
        case (in_aluc)
            ALU_ADD:  alu_res = in_a + in_b;
            ALU_SUB:  alu_res = in_a - in_b;
            ALU_AND:  alu_res = in_a & in_b;
            ALU_OR:   alu_res = in_a | in_b;
            ALU_XOR:  alu_res = in_a ^ in_b;
            ALU_NOR:  alu_res = ~(in_a | in_b);
            ALU_SLL:  alu_res = in_b << shamt;
            ALU_SRL:  alu_res = in_b >> shamt;
            ALU_SRA:  alu_res = $signed(in_b) >>> shamt;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            default:  alu_known = 1'b0;
        endcase
        sa = in_a[WIDTH-1];
        sb = in_b[WIDTH-1];
        sr = alu_res[WIDTH-1];
        alu_ovf = 1'b0;
        if (in_aluc == ALU_ADD) alu_ovf = (sa == sb) && (sr != sa);
        if (in_aluc == ALU_SUB) alu_ovf = (sa != sb) && (sr != sa);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_tag_d   = out_tag_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        if (state_q == ST_MUL) begin
            if (mul_done) begin
                out_valid_d = 1'b1;
                out_r_d     = mul_result;
                out_zero_d  = (mul_result == '0);
                out_ovf_d   = 1'b0;
            end
        end else if (accept) begin
            out_tag_d = in_tag;
            if (mul_start) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b1;
                out_r_d     = alu_res;
                out_zero_d  = alu_known && (alu_res == '0);
                out_ovf_d   = alu_ovf;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_tag_q   <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_tag_q   <= out_tag_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_tag   = out_tag_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32, TAG_W=5).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_alu_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_aluc;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic [4:0]  out_tag;
    logic        out_zero;
    logic        out_ovf;

    int unsigned checks;
    int unsigned passed;

    alu_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_aluc   (in_aluc),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        in_valid = 1'b1;
        in_aluc  = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_aluc = '0; in_a = '0; in_b = '0; in_tag = '0;
        tick(); tick();
        checks++;
        if ({out_valid, out_r, out_tag, out_zero, out_ovf, in_ready} !== 41'd0)
            $display("FAIL reset_state: got valid=%b r=%h tag=%h z=%b o=%b rdy=%b, want all 0",
                     out_valid, out_r, out_tag, out_zero, out_ovf, in_ready);
        else passed++;
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_add_ovf();
        @(negedge clk); drive(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd3);
        tick(); in_valid = 1'b0;
        checks++;
        if ({out_valid, out_r, out_ovf, out_zero, out_tag} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0, 5'd3})
            $display("FAIL add_ovf: got v=%b r=%h o=%b z=%b tag=%0d want v=1 r=80000000 o=1 z=0 tag=3",
                     out_valid, out_r, out_ovf, out_zero, out_tag);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic rdy_ok;
        @(negedge clk); drive(4'd4, 32'd5, 32'd5, 5'd1);
        rdy_ok = (in_ready === 1'b1);
        tick();
        checks++;
        if ({out_valid, out_r, out_zero, out_ovf, out_tag} !== {1'b1, 32'h0, 1'b1, 1'b0, 5'd1})
            $display("FAIL b2b_sub: got v=%b r=%h z=%b o=%b tag=%0d want v=1 r=0 z=1 o=0 tag=1",
                     out_valid, out_r, out_zero, out_ovf, out_tag);
        else passed++;
        @(negedge clk); drive(4'd6, 32'd4, 32'h8000_0000, 5'd2);
        rdy_ok = rdy_ok && (in_ready === 1'b1);
        tick(); in_valid = 1'b0;
        checks++;
        if ({out_valid, out_r, out_zero, out_tag} !== {1'b1, 32'hF800_0000, 1'b0, 5'd2})
            $display("FAIL b2b_sra: got v=%b r=%h z=%b tag=%0d want v=1 r=f8000000 z=0 tag=2",
                     out_valid, out_r, out_zero, out_tag);
        else passed++;
        checks++;
        if (!rdy_ok) $display("FAIL b2b_ready: got in_ready low during back-to-back, want 1");
        else passed++;
        tick();
        checks++;
        if ({out_valid, out_r} !== {1'b0, 32'hF800_0000})
            $display("FAIL drain: got v=%b r=%h want v=0 r=f8000000", out_valid, out_r);
        else passed++;
    endtask

    task automatic test_mul();
        int unsigned bad;
        bad = 0;
        @(negedge clk); drive(4'd10, 32'hFFFF_FFFF, 32'd3, 5'd7);
        tick(); in_valid = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
        for (int i = 1; i < 32; i++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL mul_busy: got %0d cycles with valid/ready high, want 0", bad);
        else passed++;
        tick();
        checks++;
        if ({out_valid, out_r, out_tag, out_ovf, out_zero} !== {1'b1, 32'hFFFF_FFFD, 5'd7, 1'b0, 1'b0})
            $display("FAIL mul_result: got v=%b r=%h tag=%0d o=%b z=%b want v=1 r=fffffffd tag=7 o=0 z=0",
                     out_valid, out_r, out_tag, out_ovf, out_zero);
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        int unsigned bad;
        bad = 0;
        @(negedge clk); drive(4'd5, 32'h0000_00F0, 32'h0000_000F, 5'd4); out_ready = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_r, out_tag} !== {1'b1, 32'hFF, 5'd4})
            $display("FAIL bp_or: got v=%b r=%h tag=%0d want v=1 r=ff tag=4", out_valid, out_r, out_tag);
        else passed++;
        drive(4'd0, 32'd1, 32'd1, 5'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_r !== 32'hFF || out_tag !== 5'd4) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
        else passed++;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready);
        else passed++;
        tick(); in_valid = 1'b0;
        checks++;
        if ({out_valid, out_r, out_tag, out_ovf} !== {1'b1, 32'd2, 5'd9, 1'b0})
            $display("FAIL bp_next: got v=%b r=%h tag=%0d o=%b want v=1 r=2 tag=9 o=0",
                     out_valid, out_r, out_tag, out_ovf);
        else passed++;
    endtask

    task automatic test_misc_ops();
        logic [3:0]  ops  [8] = '{4'd8, 4'd9, 4'd13, 4'd3, 4'd7, 4'd2, 4'd11, 4'd4};
        logic [31:0] as   [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'd33, 32'd4,
                                  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h8000_0000};
        logic [31:0] bs   [8] = '{32'd1, 32'd1, 32'h5678, 32'd1, 32'h8000_0000,
                                  32'hFF00_FF00, 32'h0000_F0F0, 32'd1};
        logic [31:0] exp_r[8] = '{32'd1, 32'd0, 32'd0, 32'd2, 32'h0800_0000,
                                  32'h0FF0_0FF0, 32'hF0F0_0F0F, 32'h7FFF_FFFF};
        logic        exp_z[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        exp_o[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drive(ops[i], as[i], bs[i], 5'(i + 10));
            tick();
            checks++;
            if ({out_valid, out_r, out_zero, out_ovf, out_tag} !== {1'b1, exp_r[i], exp_z[i], exp_o[i], 5'(i + 10)})
                $display("FAIL op%0d: got v=%b r=%h z=%b o=%b tag=%0d want v=1 r=%h z=%b o=%b tag=%0d",
                         ops[i], out_valid, out_r, out_zero, out_ovf, out_tag,
                         exp_r[i], exp_z[i], exp_o[i], i + 10);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        int unsigned stale;
        stale = 0;
        @(negedge clk); drive(4'd10, 32'd5, 32'd7, 5'd6);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        @(negedge clk); rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL rst_mul_valid: got %b want 0", out_valid);
        else passed++;
        @(negedge clk); rst = 1'b0;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL rst_mul_ready: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) $display("FAIL rst_mul_stale: got %0d cycles with out_valid=1, want 0", stale);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_add_ovf();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_misc_ops();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, want finish before 100000");
        $fatal(1);
    end

endmodule
